// File: rtl/cog_pkg.sv
// Shared definitions for the CoG centroid divider: record field layout,
// output beat layout and the controller state encoding.
package cog_pkg;

    localparam int SUMIC_W   = 30;
    localparam int SUMI_W    = 23;
    localparam int START_W   = 11;
    localparam int SUMIC_LSB = 0;
    localparam int SUMI_LSB  = 30;
    localparam int START_LSB = 53;
    localparam int REC_W     = 64;

    localparam int CENT_W       = 16;
    localparam int OUT_LINE_LSB = 16;
    localparam int OUT_LINE_W   = 11;
    localparam int OUT_SAT_BIT  = 30;
    localparam int OUT_ZDIV_BIT = 31;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIVIDE = 3'd2,
        S_ADD    = 3'd3,
        S_OUTPUT = 3'd4
    } cog_state_e;

    typedef struct packed {
        logic [REC_W-1:0] tdata;
        logic             tuser;
        logic             tlast;
    } cog_rec_t;

    function automatic logic [31:0] pack_result(input logic [CENT_W-1:0]     centroid,
                                                input logic [OUT_LINE_W-1:0] line,
                                                input logic                  sat,
                                                input logic                  zdiv);
        return {zdiv, sat, 3'b000, line, centroid};
    endfunction

endpackage

// File: rtl/cog_centroid_divider_if.sv
// Stream bundle between the CoG result stream, the centroid divider and
// its downstream consumer.
interface cog_centroid_divider_if;

    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tuser;
    logic        s_axis_tlast;

    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        input  m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        output m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );

endinterface

// File: rtl/cog_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is produced on
// the start edge, so done pulses DVD_W cycles after start; remainder dropped.
module cog_seq_divider #(
    parameter int DVD_W = 35,
    parameter int DVR_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVR_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVR_W-1:0] rem_r;
    logic [DVR_W-1:0] dvr_r;
    logic [DVD_W-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [DVR_W-1:0] src_rem_s;
    logic [DVR_W-1:0] src_dvr_s;
    logic [DVD_W-1:0] src_quo_s;
    logic [DVR_W:0]   shifted_s;
    logic [DVR_W-1:0] next_rem_s;
    logic [DVD_W-1:0] next_quo_s;
    logic             qbit_s;

    // One restoring step, fed from the operands on start or the running state
    always_comb begin
        src_rem_s  = rem_r;
        src_quo_s  = quo_r;
        src_dvr_s  = dvr_r;
        next_rem_s = '0;
        qbit_s     = 1'b0;
        if (start) begin
            src_rem_s = '0;
            src_quo_s = dividend;
            src_dvr_s = divisor;
        end else begin
            src_rem_s = rem_r;
            src_quo_s = quo_r;
            src_dvr_s = dvr_r;
        end
        shifted_s = {src_rem_s, src_quo_s[DVD_W-1]};
        if (shifted_s >= {1'b0, src_dvr_s}) begin
            next_rem_s = DVR_W'(shifted_s - {1'b0, src_dvr_s});
            qbit_s     = 1'b1;
        end else begin
            next_rem_s = shifted_s[DVR_W-1:0];
            qbit_s     = 1'b0;
        end
        next_quo_s = {src_quo_s[DVD_W-2:0], qbit_s};
    end

    // Iteration state, step counter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= '0;
            dvr_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rem_r  <= next_rem_s;
                quo_r  <= next_quo_s;
                dvr_r  <= divisor;
                cnt_r  <= CNT_W'(DVD_W - 1);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                rem_r <= next_rem_s;
                quo_r <= next_quo_s;
                cnt_r <= cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/cog_centroid_divider.sv
// Buffers CoG figure records and turns each into a saturating fixed-point
// centroid start_point + sum_Ic/sum_I, tagged with its line index.
module cog_centroid_divider
    import cog_pkg::*;
#(
    parameter int FRAC_BITS  = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_W     = 11
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    cog_centroid_divider_if.slave axis,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DVD_W = SUMIC_W + FRAC_BITS;
    localparam int SUM_W = DVD_W + 1;

    cog_rec_t         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             overflow_r;
    cog_rec_t         in_rec_s;
    cog_rec_t         head_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    cog_state_e          state_r;
    logic [START_W-1:0]  start_r;
    logic [SUMI_W-1:0]   sumi_r;
    logic [SUMIC_W-1:0]  sumic_r;
    logic                tuser_r;
    logic                tlast_r;
    logic                zdiv_r;
    logic                busy_r;
    logic [LINE_W-1:0]   line_r;
    logic [LINE_W-1:0]   line_cnt_r;
    logic [LINE_W-1:0]   line_idx_s;
    logic [LINE_W-1:0]   line_cnt_next_s;
    logic [31:0]         out_data_r;
    logic                out_user_r;
    logic                out_last_r;
    logic                out_valid_r;

    logic                div_start_s;
    logic                div_busy_s;
    logic                div_done_s;
    logic [DVD_W-1:0]    div_quot_s;
    logic [DVD_W-1:0]    quot_s;
    logic [SUM_W-1:0]    sum_s;
    logic                sat_s;
    logic [CENT_W-1:0]   centroid_s;

    assign in_rec_s = {axis.s_axis_tdata, axis.s_axis_tuser, axis.s_axis_tlast};
    assign head_s   = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                      (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign pop_s    = !empty_s && ((state_r == S_IDLE) ||
                                   ((state_r == S_OUTPUT) && axis.m_axis_tready));
    assign push_s   = axis.s_axis_tvalid && (!full_s || pop_s);

    // Record storage
    always_ff @(posedge i_sys_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= in_rec_s;
        end
    end

    // FIFO pointers and sticky drop flag
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W + 1)'(1);
            end
            if (axis.s_axis_tvalid && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Line index of the head record and the counter value after it
    always_comb begin
        line_idx_s      = '0;
        line_cnt_next_s = line_cnt_r;
        if (head_s.tuser) begin
            line_idx_s      = '0;
            line_cnt_next_s = head_s.tlast ? LINE_W'(1) : LINE_W'(0);
        end else begin
            line_idx_s      = line_cnt_r;
            line_cnt_next_s = head_s.tlast ? (line_cnt_r + LINE_W'(1)) : line_cnt_r;
        end
    end

    // Centroid sum with saturation to the 16-bit output field
    always_comb begin
        quot_s     = '0;
        centroid_s = '0;
        if (zdiv_r) begin
            quot_s = '0;
        end else begin
            quot_s = div_quot_s;
        end
        sum_s = SUM_W'({start_r, {FRAC_BITS{1'b0}}}) + SUM_W'(quot_s);
        sat_s = |sum_s[SUM_W-1:CENT_W];
        if (sat_s) begin
            centroid_s = 16'hFFFF;
        end else begin
            centroid_s = sum_s[CENT_W-1:0];
        end
    end

    assign div_start_s = (state_r == S_LOAD) && (sumi_r != '0);

    cog_seq_divider #(
        .DVD_W (DVD_W),
        .DVR_W (SUMI_W)
    ) u_div (
        .clk      (i_sys_clk),
        .rst_n    (i_sys_aresetn),
        .start    (div_start_s),
        .dividend ({sumic_r, {FRAC_BITS{1'b0}}}),
        .divisor  (sumi_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Controller: record capture, sequencing and the registered output beat
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_r     <= S_IDLE;
            start_r     <= '0;
            sumi_r      <= '0;
            sumic_r     <= '0;
            tuser_r     <= 1'b0;
            tlast_r     <= 1'b0;
            zdiv_r      <= 1'b0;
            busy_r      <= 1'b0;
            line_r      <= '0;
            line_cnt_r  <= '0;
            out_data_r  <= '0;
            out_user_r  <= 1'b0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (pop_s) begin
                start_r    <= head_s.tdata[START_LSB +: START_W];
                sumi_r     <= head_s.tdata[SUMI_LSB +: SUMI_W];
                sumic_r    <= head_s.tdata[SUMIC_LSB +: SUMIC_W];
                tuser_r    <= head_s.tuser;
                tlast_r    <= head_s.tlast;
                line_r     <= line_idx_s;
                line_cnt_r <= line_cnt_next_s;
            end
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        state_r <= S_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (sumi_r == '0) begin
                        zdiv_r  <= 1'b1;
                        state_r <= S_ADD;
                    end else begin
                        zdiv_r  <= 1'b0;
                        state_r <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (div_done_s) begin
                        state_r <= S_ADD;
                    end else if (!div_busy_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_ADD: begin
                    out_data_r  <= pack_result(centroid_s, OUT_LINE_W'(line_r), sat_s, zdiv_r);
                    out_user_r  <= tuser_r;
                    out_last_r  <= tlast_r;
                    out_valid_r <= 1'b1;
                    state_r     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (axis.m_axis_tready) begin
                        out_valid_r <= 1'b0;
                        if (pop_s) begin
                            state_r <= S_LOAD;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign axis.m_axis_tdata  = out_data_r;
    assign axis.m_axis_tvalid = out_valid_r;
    assign axis.m_axis_tuser  = out_user_r;
    assign axis.m_axis_tlast  = out_last_r;
    assign o_overflow         = overflow_r;
    assign o_busy             = busy_r;

endmodule

// File: doc/cog_centroid_divider.md
Name: cog_centroid_divider

Overview:
- Sits directly downstream of the CoG top-level result stream (`m_axis_*`, no tready).
- Each incoming 64-bit beat is one figure record: {start_point, sum_of_I, sum_of_I_mult_coord}.
- The block buffers records, runs a sequential divide, and emits a fixed-point centroid: start_point + sum_of_I_mult_coord/sum_of_I.
- Output is a 32-bit AXI-Stream with backpressure, tagged with a line index.

Parameters:
- FRAC_BITS, 5, fractional bits of the centroid (Q11.FRAC_BITS). Packing below is fixed for 5.
- FIFO_DEPTH, 16, input record FIFO depth (power of two).
- LINE_W, 11, line counter width.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_aresetn  in  1  reset; asynchronous assert, active-low
- s_axis_tdata  in  64  [29:0] sum_of_I_mult_coord, [52:30] sum_of_I, [63:53] start_point
- s_axis_tvalid  in  1  record valid (no backpressure upstream)
- s_axis_tuser  in  1  first record of frame
- s_axis_tlast  in  1  last record of a line
- m_axis_tdata  out  32  [15:0] centroid Q11.5, [26:16] line index, [29:27] 0, [30] saturated, [31] zero_divisor
- m_axis_tvalid  out  1  output valid
- m_axis_tuser  out  1  copied from record
- m_axis_tlast  out  1  copied from record
- m_axis_tready  in  1  downstream ready
- o_overflow  out  1  sticky: a record was dropped
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-low): FIFO empty; FSM in IDLE; line counter 0. All outputs 0.
- FIFO push: on s_axis_tvalid, stores {tdata, tuser, tlast}.
  - If full and no pop in the same cycle: drop the record and set o_overflow.
  - Push and pop in the same cycle while full: accepted, no overflow.
- o_overflow is cleared only by reset.
- Line index, evaluated at pop time:
  - tuser record: index = 0, counter := 1 if tlast else 0.
  - Otherwise: index = counter; counter increments after a tlast record.
  - Counter wraps at 2^LINE_W.
- FSM states: IDLE, LOAD, DIVIDE, ADD, OUTPUT.
  - IDLE: FIFO not empty -> pop, go to LOAD.
  - LOAD: dividend = sum_of_I_mult_coord << FRAC_BITS (35 bits); divisor = sum_of_I.
    - If divisor == 0: quotient = 0, zero_divisor = 1, skip to ADD.
    - Otherwise go to DIVIDE.
  - DIVIDE: restoring divide, one quotient bit per cycle, exactly 30+FRAC_BITS = 35 cycles, then ADD.
  - ADD: sum = (start_point << FRAC_BITS) + quotient, 36-bit.
    - If sum > 16'hFFFF: centroid = 16'hFFFF, saturated = 1.
    - Load the output register and assert m_axis_tvalid. Go to OUTPUT.
  - OUTPUT: hold tdata/tuser/tlast stable while tvalid && !tready.
    - On tready: deassert tvalid.
    - Go to IDLE, or pop directly into LOAD if the FIFO is not empty.
- Latency:
  - Nonzero divisor: pop to m_axis_tvalid = 37 cycles.
  - Zero divisor: 2 cycles.
  - Throughput: at most one record per 38 cycles with tready held high.
- Capacity: FIFO_DEPTH records plus one in flight.
- Quotient is truncated (floor); no rounding.
- Reset mid-divide or mid-OUTPUT: record lost, m_axis_tvalid drops asynchronously, no partial beat is emitted afterwards.

Decomposition:
- Shared package `cog_pkg`:
  - input field offsets/widths (SUMIC_W=30, SUMI_W=23, START_W=11);
  - output bit positions;
  - FSM state enum.
- Sub-module `cog_seq_divider`:
  - parameterised dividend/divisor widths;
  - start/busy/done handshake;
  - remainder discarded.
- FIFO is inline, or the team's existing sync FIFO if one is already present.

Test Plan:
- Basic: start=100, sum_I=10, sum_Ic=35, tuser=1, tlast=1, tready=1 -> one beat 37 cycles after pop. tdata[15:0]=0x0CF0 (103.5), line=0, flags 0, tuser=1, tlast=1.
- Zero divisor: start=50, sum_I=0, sum_Ic=7 -> tdata[15:0]=0x0640, bit31=1, 2-cycle latency.
- Saturation: start=2047, sum_I=1, sum_Ic=2^30-1 -> tdata[15:0]=0xFFFF, bit30=1.
- Line counting: frame of tuser rec, rec(tlast), rec, rec(tlast), rec -> line indices 0,0,1,1,2. A new tuser restarts at 0.
- Overflow/backpressure:
  - Hold tready=0 and push 20 back-to-back records -> exactly FIFO_DEPTH+1 = 17 retained and output in order after tready=1. o_overflow=1; output beat stable while stalled.
  - Push and pop in the same cycle while full -> o_overflow stays 0.
- Reset: assert reset during DIVIDE -> outputs 0 immediately, o_overflow=0. The next record after release gives a correct result with line index restarting at 0.
